// File: rtl/im_loader.sv
// Instruction memory loader: packs a [N][data...][CHK] byte stream into 32-bit
// little-endian words, writes them from word 0, and releases cpu_rst on a good load.
module im_loader #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [7:0]          acc_q, acc_d;
    logic [1:0]          k_q, k_d;
    logic                accept;

    assign accept = byte_valid && byte_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            last_q  <= '0;
            wdata_q <= '0;
            acc_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            wdata_q <= wdata_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        wdata_d = wdata_q;
        acc_d   = acc_q;
        k_d     = k_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_d = S_LEN;
            end
            S_LEN: begin
                if (accept) begin
                    if (byte_data == 8'd0 || 32'(byte_data) > DEPTH) begin
                        state_d = S_ERR;
                    end else begin
                        // Store N-1 so the last-word test needs no extra address bit.
                        last_d  = ADDR_W'(byte_data - 8'd1);
                        addr_d  = '0;
                        acc_d   = '0;
                        k_d     = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    wdata_d[{k_q, 3'b000} +: 8] = byte_data;
                    acc_d = acc_q ^ byte_data;
                    k_d   = k_q + 2'd1;
                    if (k_q == 2'd3) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (addr_q == last_q) begin
                    state_d = S_CSUM;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_DATA;
                end
            end
            S_CSUM: begin
                if (accept) state_d = (byte_data == acc_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
        im_we      = (state_q == S_WRITE);
        busy       = byte_ready || im_we;
        done       = (state_q == S_DONE);
        err        = (state_q == S_ERR);
        cpu_rst    = (state_q != S_DONE);
        im_addr    = addr_q;
        im_wdata   = wdata_q;
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: expected word writes are queued as bytes are driven
// and checked by a write monitor; load status is checked after each stream.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        im_we;
    logic [5:0]  im_addr;
    logic [31:0] im_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int          checks   = 0;
    int          failures = 0;
    logic [37:0] exp_q[$];
    logic [31:0] img[64];

    im_loader #(.ADDR_W(6), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every im_we cycle must match the oldest queued word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && im_we === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_write observed=%0h expected=none", {im_addr, im_wdata});
            end
            if (exp_q.size() != 0) begin
                logic [37:0] e;
                e = exp_q.pop_front();
                checks++;
                assert ({im_addr, im_wdata} === e) else begin
                    failures++;
                    $error("FAIL write observed=%0h expected=%0h", {im_addr, im_wdata}, e);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gaps, input bit pulse_start);
        int cnt;
        for (int i = 0; i < gaps; i++) begin
            @(negedge clk);
            byte_valid = 1'b0;
            start = pulse_start ? 1'($urandom_range(0, 1)) : 1'b0;
            if (pulse_start) chk("busy_in_gap", 64'(busy), 64'd1);
        end
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        cnt = 0;
        while (byte_ready !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("ready_timeout", 64'(cnt < 100), 64'd1);
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic pulse_start_cycle();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("cpu_rst_after_start", 64'(cpu_rst), 64'd1);
        chk("done_after_start", 64'(done), 64'd0);
        chk("err_after_start", 64'(err), 64'd0);
    endtask

    task automatic run_load(input logic [7:0] nbyte, input bit bad_chk, input bit rnd);
        int          nwords;
        logic [7:0]  acc;
        logic [7:0]  b;
        bit          ok;
        nwords = (nbyte == 8'd0 || nbyte > 8'd64) ? 0 : int'(nbyte);
        ok     = (nwords != 0) && !bad_chk;
        acc    = 8'h00;
        pulse_start_cycle();
        send_byte(nbyte, rnd ? int'($urandom_range(0, 3)) : 0, rnd);
        if (nwords != 0) begin
            for (int w = 0; w < nwords; w++) begin
                for (int k = 0; k < 4; k++) begin
                    b   = img[w][8*k +: 8];
                    acc = acc ^ b;
                    if (k == 3) exp_q.push_back({6'(w), img[w]});
                    send_byte(b, rnd ? int'($urandom_range(0, 3)) : 0, rnd);
                end
            end
            send_byte(bad_chk ? (acc ^ 8'h01) : acc, rnd ? int'($urandom_range(0, 3)) : 0, rnd);
        end
        @(negedge clk);
        chk("done", 64'(done), 64'(ok));
        chk("err", 64'(err), 64'(!ok));
        chk("cpu_rst", 64'(cpu_rst), 64'(!ok));
        chk("busy_end", 64'(busy), 64'd0);
        chk("pending_writes", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_byte_ready", 64'(byte_ready), 64'd0);
        chk("rst_im_we", 64'(im_we), 64'd0);
        chk("rst_im_addr", 64'(im_addr), 64'd0);
        chk("rst_im_wdata", 64'(im_wdata), 64'd0);
        chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst_n = 1'b1;

        // T1 / T2
        img[0] = 32'h0000_0013;
        img[1] = 32'h0050_0093;
        run_load(8'd2, 1'b0, 1'b0);
        run_load(8'd2, 1'b1, 1'b0);

        // T3: length boundaries
        run_load(8'd0, 1'b0, 1'b0);
        run_load(8'd65, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) img[i] = $urandom;
        run_load(8'd64, 1'b0, 1'b0);

        // T4: T1 image with random gaps and start pulses while busy
        img[0] = 32'h0000_0013;
        img[1] = 32'h0050_0093;
        run_load(8'd2, 1'b0, 1'b1);

        // T5: reset after 6 data bytes
        pulse_start_cycle();
        send_byte(8'd2, 0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            if (k == 3) exp_q.push_back({6'd0, img[0]});
            send_byte(img[k / 4][8*(k % 4) +: 8], 0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_im_we", 64'(im_we), 64'd0);
        chk("midrst_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_byte_ready", 64'(byte_ready), 64'd0);
        chk("midrst_im_addr", 64'(im_addr), 64'd0);
        chk("midrst_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_load(8'd2, 1'b0, 1'b0);

        // T6: reload a single word after DONE
        img[0] = 32'h00A0_0113;
        run_load(8'd1, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL global_timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
